// File: rtl/qam16_rx_ctrl_pkg.sv
// qam16_pkg: shared types and constants for the QAM16 receive controller.
// Holds the four legal constellation levels, the signed symbol type, the
// packer state enum and a helper that tells whether a level is legal.
package qam16_pkg;

    typedef logic signed [3:0] sym_t;

    localparam sym_t LVL_N3 = -4'sd3;
    localparam sym_t LVL_N1 = -4'sd1;
    localparam sym_t LVL_P1 = 4'sd1;
    localparam sym_t LVL_P3 = 4'sd3;

    typedef enum logic {
        HI = 1'b0,
        LO = 1'b1
    } pack_state_t;

    // True when the level is one of the four QAM16 amplitudes
    function automatic logic isLegalLevel(input sym_t lvl);
        return (lvl == LVL_N3) || (lvl == LVL_N1) ||
               (lvl == LVL_P1) || (lvl == LVL_P3);
    endfunction

endpackage

// File: rtl/qam16_rx_ctrl_byte_fifo.sv
// qam16_byte_fifo: small synchronous FIFO with full/empty flags.
// A write while full is accepted only when a read happens in the same
// cycle; otherwise it is ignored and the parent flags the drop. The head
// entry is read combinationally from storage, so there is no bypass path
// from write data to read data.
module qam16_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doRead;
    logic             doWrite;

    // Qualify requests against the current occupancy
    always_comb begin
        doRead  = rdEn_i && (count_q != '0);
        doWrite = wrEn_i && ((count_q != DEPTH_CNT) || doRead);
    end

    // Storage, pointers and occupancy; reset clears the contents as well
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) begin
                mem_q[wrPtr_q] <= wrData_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doRead) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doWrite && !doRead) begin
                count_q <= count_q + 1'b1;
            end else if (doRead && !doWrite) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdData_o = mem_q[rdPtr_q];
    assign full_o   = (count_q == DEPTH_CNT);
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/qam16_rx_ctrl.sv
// qam16_rx_ctrl: receive-side sequencer for the QAM16 demapper.
// Decimates the oversampled I/Q stream to one sample per symbol, drives the
// demapper from registers, packs returned nibbles (first symbol = high
// nibble) into bytes and queues them in a byte FIFO with valid/ready.
// Optional build macro QAM16_LEVEL_CHECK_EN adds a sticky lvl_err output
// flagging latched samples outside the legal {-3,-1,+1,+3} set.
module qam16_rx_ctrl
    import qam16_pkg::*;
#(
    parameter int SPS          = 4,
    parameter int SAMPLE_PHASE = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    input  logic [3:0]  i_sample,
    input  logic [3:0]  q_sample,
    output logic [3:0]  i_down,
    output logic [3:0]  q_down,
    input  logic [3:0]  nibble,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [15:0] sym_cnt
`ifdef QAM16_LEVEL_CHECK_EN
    ,
    output logic        lvl_err
`endif
);

    localparam logic [3:0] LAST_IDX  = 4'(SPS - 1);
    localparam logic [3:0] PHASE_IDX = 4'(SAMPLE_PHASE);

    logic [3:0]  sampCnt_q;
    logic [3:0]  sampCnt_d;
    sym_t        iDown_q;
    sym_t        qDown_q;
    logic        symStb_q;
    pack_state_t packState_q;
    logic [3:0]  hold_q;
    logic [15:0] symCnt_q;
    logic        ovf_q;
    logic        phaseHit;
    logic        symStbEff;
    logic        pushReq;
    logic        popReq;
    logic        dropByte;
    logic        fifoFull;
    logic        fifoEmpty;

    // Decimation decisions and packer/FIFO handshake terms for this cycle
    always_comb begin
        phaseHit  = en && in_valid && (sampCnt_q == PHASE_IDX);
        sampCnt_d = sampCnt_q;
        if (!en) begin
            sampCnt_d = '0;
        end else if (in_valid) begin
            sampCnt_d = (sampCnt_q == LAST_IDX) ? 4'd0 : sampCnt_q + 4'd1;
        end
        symStbEff = symStb_q && en;
        pushReq   = symStbEff && (packState_q == LO);
        popReq    = out_ready && !fifoEmpty;
        dropByte  = pushReq && fifoFull && !popReq;
    end

    // Sample counter, demapper input registers and the one-cycle symbol strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sampCnt_q <= '0;
            iDown_q   <= '0;
            qDown_q   <= '0;
            symStb_q  <= 1'b0;
        end else begin
            sampCnt_q <= sampCnt_d;
            symStb_q  <= phaseHit;
            if (phaseHit) begin
                iDown_q <= sym_t'(i_sample);
                qDown_q <= sym_t'(q_sample);
            end
        end
    end

    // Nibble packer FSM and symbol counter; disabling drops any half byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            packState_q <= HI;
            hold_q      <= '0;
            symCnt_q    <= '0;
        end else if (!en) begin
            packState_q <= HI;
        end else if (symStb_q) begin
            symCnt_q <= symCnt_q + 16'd1;
            case (packState_q)
                HI: begin
                    hold_q      <= nibble;
                    packState_q <= LO;
                end
                LO: begin
                    packState_q <= HI;
                end
                default: begin
                    packState_q <= HI;
                end
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (dropByte) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef QAM16_LEVEL_CHECK_EN
    logic lvlErr_q;

    // Sticky flag for latched samples outside the constellation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvlErr_q <= 1'b0;
        end else if (phaseHit && (!isLegalLevel(sym_t'(i_sample)) ||
                                  !isLegalLevel(sym_t'(q_sample)))) begin
            lvlErr_q <= 1'b1;
        end else if (ovf_clr) begin
            lvlErr_q <= 1'b0;
        end
    end

    assign lvl_err = lvlErr_q;
`endif

    qam16_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrEn_i   (pushReq),
        .wrData_i ({hold_q, nibble}),
        .rdEn_i   (out_ready),
        .rdData_o (out_data),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    assign i_down    = iDown_q;
    assign q_down    = qDown_q;
    assign out_valid = !fifoEmpty;
    assign overflow  = ovf_q;
    assign sym_cnt   = symCnt_q;

endmodule

// File: tb/tb_qam16_rx_ctrl.sv
// tb_qam16_rx_ctrl: self-checking bench for qam16_rx_ctrl.
// A behavioural demapper drives the nibble input. Directed table and
// sequences cover the named corner cases; a randomized phase is compared
// cycle by cycle against a queue-based reference model.
// Define QAM16_LEVEL_CHECK_EN to also exercise the lvl_err output.
module tb_qam16_rx_ctrl;

    localparam int SPS   = 4;
    localparam int PHASE = 1;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               in_valid;
    logic signed [3:0]  i_sample;
    logic signed [3:0]  q_sample;
    logic signed [3:0]  i_down;
    logic signed [3:0]  q_down;
    logic [3:0]         nibble;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic               ovf_clr;
    logic [15:0]        sym_cnt;
`ifdef QAM16_LEVEL_CHECK_EN
    logic               lvl_err;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                mCnt;
    logic              mStb;
    logic              mLo;
    logic [3:0]        mHold;
    logic signed [3:0] mI;
    logic signed [3:0] mQ;
    logic [15:0]       mSym;
    logic              mOvf;
    logic              mLvl;
    logic [7:0]        mQueue[$];

    typedef struct {
        logic              en;
        logic              inValid;
        logic signed [3:0] iS;
        logic signed [3:0] qS;
        logic              ready;
        logic              expValid;
        logic [7:0]        expData;
        logic [15:0]       expSym;
        logic              expOvf;
    } vec_t;

    vec_t tbl[9];

    qam16_rx_ctrl #(
        .SPS          (SPS),
        .SAMPLE_PHASE (PHASE),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .i_sample  (i_sample),
        .q_sample  (q_sample),
        .i_down    (i_down),
        .q_down    (q_down),
        .nibble    (nibble),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .sym_cnt   (sym_cnt)
`ifdef QAM16_LEVEL_CHECK_EN
        ,
        .lvl_err   (lvl_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Demapper behaviour: -3,-1,+1,+3 -> 00,01,10,11; anything else -> 00
    function automatic logic [1:0] bitsOf(input logic signed [3:0] v);
        int x;
        x = v;
        if (x == -1) return 2'b01;
        if (x == 1)  return 2'b10;
        if (x == 3)  return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic signed [3:0] levelOf(input logic [1:0] b);
        logic signed [3:0] lv;
        case (b)
            2'b00:   lv = -4'sd3;
            2'b01:   lv = -4'sd1;
            2'b10:   lv = 4'sd1;
            default: lv = 4'sd3;
        endcase
        return lv;
    endfunction

    function automatic logic legal(input logic signed [3:0] v);
        int x;
        x = v;
        return (x == -3) || (x == -1) || (x == 1) || (x == 3);
    endfunction

    assign nibble = {bitsOf(i_down), bitsOf(q_down)};

    // One clock edge of the reference model, using the inputs seen at that edge
    task automatic modelStep();
        logic [3:0] nib;
        logic       pop;
        logic       stbEff;
        logic       push;
        logic       drop;
        if (!rst_n) begin
            mCnt = 0; mStb = 0; mLo = 0; mHold = '0; mI = '0; mQ = '0;
            mSym = '0; mOvf = 0; mLvl = 0;
            mQueue.delete();
            return;
        end
        nib    = {bitsOf(mI), bitsOf(mQ)};
        pop    = (mQueue.size() > 0) && out_ready;
        stbEff = mStb && en;
        push   = stbEff && mLo;
        drop   = 1'b0;
        if (pop) void'(mQueue.pop_front());
        if (push) begin
            if (mQueue.size() < DEPTH) mQueue.push_back({mHold, nib});
            else drop = 1'b1;
        end
        if (drop) mOvf = 1'b1;
        else if (ovf_clr) mOvf = 1'b0;
        if (en && in_valid && mCnt == PHASE && (!legal(i_sample) || !legal(q_sample)))
            mLvl = 1'b1;
        else if (ovf_clr)
            mLvl = 1'b0;
        if (stbEff) begin
            mSym = mSym + 16'd1;
            if (!mLo) begin
                mHold = nib;
                mLo   = 1'b1;
            end else begin
                mLo = 1'b0;
            end
        end
        if (!en) begin
            mCnt = 0; mLo = 0; mStb = 0;
        end else if (in_valid) begin
            if (mCnt == PHASE) begin
                mI = i_sample; mQ = q_sample; mStb = 1'b1;
            end else begin
                mStb = 1'b0;
            end
            mCnt = (mCnt + 1) % SPS;
        end else begin
            mStb = 1'b0;
        end
    endtask

    // Advance one clock with the current inputs and settle at the falling edge
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        rst_n = 0; en = 0; in_valid = 0; i_sample = '0; q_sample = '0;
        out_ready = 0; ovf_clr = 0;
        applyStimulus();
        rst_n = 1; en = 1;
    endtask

    // One symbol window: the level pair sits at the phase index, the others carry decoys
    task automatic sendSymbol(input logic signed [3:0] iv, input logic signed [3:0] qv, input logic readyAtPush);
        for (int idx = 0; idx < SPS; idx++) begin
            in_valid  = 1'b1;
            i_sample  = (idx == PHASE) ? iv : -4'sd3;
            q_sample  = (idx == PHASE) ? qv : 4'sd3;
            out_ready = (idx == PHASE + 1) ? readyAtPush : 1'b0;
            applyStimulus();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic readyLast);
        sendSymbol(levelOf(b[7:6]), levelOf(b[5:4]), 1'b0);
        sendSymbol(levelOf(b[3:2]), levelOf(b[1:0]), readyLast);
    endtask

    task automatic drainExpect(input logic [7:0] exp0, input logic [7:0] exp1,
                               input logic [7:0] exp2, input logic [7:0] exp3, input string tag);
        logic [7:0] e[4];
        e[0] = exp0; e[1] = exp1; e[2] = exp2; e[3] = exp3;
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_data"}, 32'(out_data), 32'(e[k]));
            out_ready = 1'b1;
            applyStimulus();
            out_ready = 1'b0;
        end
        checkOutput({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Table: two symbols giving 0xD2, then one pop
        tbl[0] = '{1, 1,  4'sd0,  4'sd0, 0, 0, 8'h00, 16'd0, 0};
        tbl[1] = '{1, 1,  4'sd3, -4'sd1, 0, 0, 8'h00, 16'd0, 0};
        tbl[2] = '{1, 1,  4'sd0,  4'sd0, 0, 0, 8'h00, 16'd1, 0};
        tbl[3] = '{1, 1,  4'sd0,  4'sd0, 0, 0, 8'h00, 16'd1, 0};
        tbl[4] = '{1, 1,  4'sd0,  4'sd0, 0, 0, 8'h00, 16'd1, 0};
        tbl[5] = '{1, 1, -4'sd3,  4'sd1, 0, 0, 8'h00, 16'd1, 0};
        tbl[6] = '{1, 1,  4'sd0,  4'sd0, 0, 1, 8'hD2, 16'd2, 0};
        tbl[7] = '{1, 0,  4'sd0,  4'sd0, 0, 1, 8'hD2, 16'd2, 0};
        tbl[8] = '{1, 0,  4'sd0,  4'sd0, 1, 0, 8'h00, 16'd2, 0};

        resetDut();
        checkOutput("rst_i_down", 32'(i_down), 32'd0);
        checkOutput("rst_q_down", 32'(q_down), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_sym_cnt", 32'(sym_cnt), 32'd0);

        for (int r = 0; r < 9; r++) begin
            en = tbl[r].en; in_valid = tbl[r].inValid;
            i_sample = tbl[r].iS; q_sample = tbl[r].qS; out_ready = tbl[r].ready;
            applyStimulus();
            checkOutput($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(tbl[r].expValid));
            if (tbl[r].expValid)
                checkOutput($sformatf("tbl%0d_data", r), 32'(out_data), 32'(tbl[r].expData));
            checkOutput($sformatf("tbl%0d_sym", r), 32'(sym_cnt), 32'(tbl[r].expSym));
            checkOutput($sformatf("tbl%0d_ovf", r), 32'(overflow), 32'(tbl[r].expOvf));
        end
        in_valid = 0; out_ready = 0;

        // Five bytes into a four-deep FIFO with the sink stalled
        resetDut();
        sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0);
        sendByte(8'h44, 0); sendByte(8'h55, 0);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_sym_cnt", 32'(sym_cnt), 32'd10);
        drainExpect(8'h11, 8'h22, 8'h33, 8'h44, "ovf_drain");
        checkOutput("ovf_still_set", 32'(overflow), 32'd1);
        ovf_clr = 1; applyStimulus(); ovf_clr = 0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO, pop coincides with push
        resetDut();
        sendByte(8'h11, 0); sendByte(8'h22, 0); sendByte(8'h33, 0); sendByte(8'h44, 0);
        sendByte(8'h55, 1);
        checkOutput("fullpp_ovf", 32'(overflow), 32'd0);
        drainExpect(8'h22, 8'h33, 8'h44, 8'h55, "fullpp_drain");

        // Enable drop discards the pending half byte
        resetDut();
        sendSymbol(4'sd3, 4'sd3, 0);
        en = 0; applyStimulus(); en = 1;
        sendSymbol(4'sd1, 4'sd1, 0);
        sendSymbol(-4'sd1, -4'sd1, 0);
        checkOutput("endrop_valid", 32'(out_valid), 32'd1);
        checkOutput("endrop_data", 32'(out_data), 32'hA5);
        out_ready = 1; applyStimulus(); out_ready = 0;
        checkOutput("endrop_one_byte", 32'(out_valid), 32'd0);

        // in_valid toggling: phase chosen from valid samples only
        resetDut();
        for (int n = 0; n < 8; n++) begin
            in_valid = 1;
            i_sample = (n == 1) ? 4'sd1 : (n == 5) ? 4'sd3 : -4'sd3;
            q_sample = (n == 1) ? -4'sd1 : (n == 5) ? 4'sd3 : 4'sd1;
            applyStimulus();
            in_valid = 0; i_sample = 4'sd3; q_sample = -4'sd3;
            applyStimulus();
        end
        checkOutput("gap_valid", 32'(out_valid), 32'd1);
        checkOutput("gap_data", 32'(out_data), 32'h9F);
        checkOutput("gap_sym_cnt", 32'(sym_cnt), 32'd2);

`ifdef QAM16_LEVEL_CHECK_EN
        // Illegal level is flagged and still packed with I bits 00
        resetDut();
        checkOutput("lvl_rst", 32'(lvl_err), 32'd0);
        sendSymbol(4'sd2, 4'sd1, 0);
        checkOutput("lvl_set", 32'(lvl_err), 32'd1);
        sendSymbol(4'sd1, 4'sd1, 0);
        checkOutput("lvl_data", 32'(out_data), 32'h2A);
        ovf_clr = 1; applyStimulus(); ovf_clr = 0;
        checkOutput("lvl_clr", 32'(lvl_err), 32'd0);
`endif

        // Randomized traffic against the reference model
        resetDut();
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 19) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            i_sample  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : levelOf(2'($urandom));
            q_sample  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : levelOf(2'($urandom));
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 39) == 0);
            applyStimulus();
            checkOutput("rnd_i_down", 32'(i_down), 32'(mI));
            checkOutput("rnd_q_down", 32'(q_down), 32'(mQ));
            checkOutput("rnd_valid", 32'(out_valid), 32'(mQueue.size() > 0));
            if (mQueue.size() > 0)
                checkOutput("rnd_data", 32'(out_data), 32'(mQueue[0]));
            checkOutput("rnd_ovf", 32'(overflow), 32'(mOvf));
            checkOutput("rnd_sym_cnt", 32'(sym_cnt), 32'(mSym));
`ifdef QAM16_LEVEL_CHECK_EN
            checkOutput("rnd_lvl", 32'(lvl_err), 32'(mLvl));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qam16_rx_ctrl.md
Name: qam16_rx_ctrl

Overview:
- Receive-side sequencer for the QAM16 demapper (desymmap).
- Decimates the oversampled I/Q stream to one sample per symbol and drives the demapper inputs from registers.
- Packs the returned 4-bit symbol nibbles into bytes and buffers them in a small FIFO with a valid/ready output.
- Sits between the matched-filter/downsample path and the byte sink (deframer/UART).

Parameters:
- SPS, 4: samples per symbol; legal range 2..16.
- SAMPLE_PHASE, 1: sample index within a symbol (0..SPS-1) that is latched for demapping.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  receive enable
- in_valid  in  1  qualifies i_sample/q_sample
- i_sample  in  4  signed I level
- q_sample  in  4  signed Q level
- i_down  out  4  registered signed I to demapper
- q_down  out  4  registered signed Q to demapper
- nibble  in  4  demapper output (I bits [3:2], Q bits [1:0])
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO not empty
- out_ready  in  1  sink accepts out_data
- overflow  out  1  sticky, set when a byte is dropped
- ovf_clr  in  1  clears overflow
- sym_cnt  out  16  symbols demapped, wraps at 0xFFFF -> 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low via rst_n; it is sampled only on the rising edge of clk.
- Reset values: all outputs 0 (i_down, q_down, out_data, out_valid, overflow, sym_cnt). Sample counter 0, packer state HI, FIFO empty.
- Sample counter:
  - Increments on each clk with en && in_valid.
  - Wraps SPS-1 -> 0.
  - Cycles without in_valid hold the count.
- Symbol latch:
  - When en && in_valid and the counter equals SAMPLE_PHASE, i_sample/q_sample are registered into i_down/q_down.
  - sym_stb is asserted, registered, for the next cycle.
- Packer FSM, states HI and LO, advances only when sym_stb = 1:
  - HI: nibble -> hold[7:4]; go to LO.
  - LO: push {hold[7:4], nibble} to the FIFO; go to HI.
  - sym_cnt increments on every sym_stb.
- Latency:
  - Phase sample on edge k gives i_down valid after edge k.
  - The nibble is consumed on edge k+1.
  - For a LO symbol, out_valid rises after edge k+1. Sample to out_valid is 2 cycles.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when full with no pop in the same cycle: the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the push is written and out_valid rises next cycle (no bypass).
- overflow: cleared by ovf_clr. If a set and a clear occur in the same cycle, set wins.
- en = 0:
  - Sample counter -> 0, packer -> HI, pending half byte discarded, sym_stb suppressed.
  - FIFO contents and output handshake are unaffected.
  - i_down/q_down hold their values.
- Reset mid-operation: everything returns to reset values next edge, including the FIFO and any partial byte.

Optional Feature:
- Macro: QAM16_LEVEL_CHECK_EN.
- Defined:
  - Adds output lvl_err (1 bit, sticky, cleared by ovf_clr, reset 0).
  - Set when a latched i_down or q_down is not in {-3, -1, +1, +3}.
  - The nibble is still packed; no other behaviour changes.
- Undefined: port absent, no checking logic.

Decomposition:
- Package qam16_pkg holds:
  - constants LVL_N3 = -3, LVL_N1 = -1, LVL_P1 = 1, LVL_P3 = 3;
  - typedef sym_t (signed 4-bit);
  - enum pack_state_t {HI, LO}.
- One sub-module: qam16_byte_fifo (parameterised synchronous FIFO with full/empty). Sampler and packer stay in the top.

Test Plan:
- SPS = 4, SAMPLE_PHASE = 1. Stream (+3,-1) at index 1 of symbol 0 and (-3,+1) at index 1 of symbol 1. Required: out_data = 0xD2, out_valid 2 cycles after the second phase sample, sym_cnt = 2.
- Hold out_ready = 0 and send 5 bytes with FIFO_DEPTH = 4. Required: first 4 bytes retained, overflow = 1. Drain gives exactly those 4 in order; ovf_clr returns overflow to 0.
- FIFO full with out_ready = 1 on the same cycle a new byte pushes. Required: no overflow, occupancy stays 4, order preserved.
- One symbol sent (packer in LO), then en dropped for 1 cycle and re-raised, then 2 symbols (+1,+1), (-1,-1). Required: one byte 0xA5; the first half byte is discarded.
- in_valid gaps (toggling 1-0-1). Required: the phase is still selected on every 4th valid sample; decimation is unaffected by idle cycles.
- With QAM16_LEVEL_CHECK_EN defined: latch I = +2. Required: lvl_err = 1 and the nibble is packed with I bits 00.
